// File: rtl/target_hit_driver_pkg.sv
// Shared game definitions: FSM state codes, LFSR feedback taps and the
// score counter's sample period, which also sets the hit pulse width.
package target_hit_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HIT   = 2'd2,
        ST_MISS  = 2'd3
    } game_state_e;

    // Taps 16,14,13,11 of a 16-bit Fibonacci LFSR, shifting toward the MSB
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned SAMPLE_PERIOD = 32'd20000002;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/target_hit_driver_debouncer.sv
// Button conditioner: two-flop synchronizer followed by a stable-count filter.
// 'clean' follows 'raw' only after it has differed for DEBOUNCE consecutive cycles.
module button_debouncer #(
    parameter int unsigned DEBOUNCE = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic clean
);

    logic        sync1_q, sync2_q;
    logic        clean_q;
    logic [31:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            clean_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            if (sync2_q == clean_q) begin
                cnt_q <= '0;
            end else if (cnt_q + 32'd1 >= DEBOUNCE) begin
                clean_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign clean = clean_q;

endmodule

// File: rtl/target_hit_driver.sv
// Reaction-game source for the score counter: lights the target after a random
// delay and turns an in-window debounced press into a HOLD_CYCLES-wide hit level.
module target_hit_driver
    import target_hit_driver_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = SAMPLE_PERIOD,
    parameter int unsigned WINDOW      = 50000000,
    parameter int unsigned MIN_DELAY   = 25000000,
    parameter int unsigned DELAY_SHIFT = 17,
    parameter int unsigned DEBOUNCE    = 500000,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       button,
    output logic       target_led,
    output logic       hit,
    output logic       miss,
    output logic [1:0] state
);

    game_state_e state_q, state_d;
    logic [15:0] lfsr_q;
    logic        load_q, load_d;
    logic [31:0] delay_q, delay_d;
    logic [31:0] win_q, win_d;
    logic [31:0] hold_q, hold_d;
    logic        led_q, hit_q, miss_q;
    logic        clean, clean_prev_q, press;
    logic [31:0] new_delay, dly_cur;

    button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_btn (
        .clock (clock),
        .reset (reset),
        .raw   (button),
        .clean (clean)
    );

    assign press     = clean & ~clean_prev_q;
    assign new_delay = 32'(MIN_DELAY) + ({24'd0, lfsr_q[7:0]} << DELAY_SHIFT);
    // The first IDLE cycle counts with the freshly drawn delay as its value
    assign dly_cur   = load_q ? new_delay : delay_q;

    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        delay_d = delay_q;
        win_d   = win_q;
        hold_d  = hold_q;
        if (!en) begin
            state_d = ST_IDLE;
            load_d  = 1'b1;
            delay_d = '0;
            win_d   = '0;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (dly_cur <= 32'd1) begin
                        state_d = ST_ARMED;
                        delay_d = '0;
                        win_d   = 32'(WINDOW);
                    end else begin
                        delay_d = dly_cur - 32'd1;
                    end
                end
                ST_ARMED: begin
                    // A press landing on the expiry cycle still scores
                    if (press) begin
                        state_d = ST_HIT;
                        win_d   = '0;
                        hold_d  = 32'(HOLD_CYCLES);
                    end else if (win_q <= 32'd1) begin
                        state_d = ST_MISS;
                        win_d   = '0;
                    end else begin
                        win_d = win_q - 32'd1;
                    end
                end
                ST_HIT: begin
                    if (hold_q <= 32'd1) begin
                        state_d = ST_IDLE;
                        load_d  = 1'b1;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q - 32'd1;
                    end
                end
                ST_MISS: begin
                    state_d = ST_IDLE;
                    load_d  = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    load_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q       <= SEED;
            state_q      <= ST_IDLE;
            load_q       <= 1'b1;
            delay_q      <= '0;
            win_q        <= '0;
            hold_q       <= '0;
            led_q        <= 1'b0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            clean_prev_q <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_next(lfsr_q);
            state_q      <= state_d;
            load_q       <= load_d;
            delay_q      <= delay_d;
            win_q        <= win_d;
            hold_q       <= hold_d;
            led_q        <= (state_d == ST_ARMED);
            hit_q        <= (state_d == ST_HIT);
            miss_q       <= (state_d == ST_MISS);
            clean_prev_q <= clean;
        end
    end

    assign target_led = led_q;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign state      = state_q;

endmodule
